// File: rtl/reaction_controller.sv
// Reaction-timer game controller.
// Waits a random pre-light delay taken from the LFSR, lights the stimulus LED,
// then measures the reaction time in milliseconds. It flags false starts and
// timeouts, and keeps the best valid time seen since reset.
module reaction_controller #(
  parameter int CNT_W        = 14,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_SCALE  = 20,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ms_tick,
  input  logic             start_btn,
  input  logic             react_btn,
  input  logic [6:0]       rand_val,
  output logic             lfsr_en,
  output logic             led_on,
  output logic [CNT_W-1:0] result_ms,
  output logic             result_valid,
  output logic [CNT_W-1:0] best_ms,
  output logic             false_start,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT        = 3'd1,
    S_REACT       = 3'd2,
    S_DONE        = 3'd3,
    S_FALSE_START = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic             r_start_prev;
  logic             r_react_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_delay_tgt;
  logic             r_led_on;
  logic [CNT_W-1:0] r_result_ms;
  logic             r_result_valid;
  logic [CNT_W-1:0] r_best_ms;
  logic             r_false_start;
  logic             r_timeout;

  logic             w_start_edge;
  logic             w_react_edge;
  logic             w_wait_done;
  logic             w_timeout_hit;
  logic [CNT_W-1:0] w_delay_calc;

  // A press counts only on the clk its level goes from low to high
  assign w_start_edge  = start_btn & ~r_start_prev;
  assign w_react_edge  = react_btn & ~r_react_prev;

  // The tick that would bring cnt up to the target ends the phase
  assign w_wait_done   = ms_tick && (r_cnt == (r_delay_tgt - CNT_W'(1)));
  assign w_timeout_hit = ms_tick && (r_cnt == CNT_W'(TIMEOUT_MS - 1));

  // Random pre-light delay: fixed part plus scaled LFSR sample, unsigned CNT_W bits
  assign w_delay_calc  = CNT_W'(MIN_DELAY_MS) + (CNT_W'(rand_val) * CNT_W'(DELAY_SCALE));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; in WAIT and REACT the react press has priority over the tick
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FALSE_START: begin
        if (w_start_edge) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_react_edge)     w_next_state = S_FALSE_START;
        else if (w_wait_done) w_next_state = S_REACT;
      end
      S_REACT: begin
        if (w_react_edge || w_timeout_hit) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs: LFSR free-runs only while no round is in progress
  always_comb begin
    busy    = 1'b0;
    lfsr_en = 1'b1;
    if (r_state == S_WAIT || r_state == S_REACT) begin
      busy    = 1'b1;
      lfsr_en = 1'b0;
    end
  end

  // Delay target latched from the LFSR on the start press
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE || r_state == S_DONE || r_state == S_FALSE_START) && w_start_edge)
      r_delay_tgt <= w_delay_calc;
  end

  // Counter, result, best time, flags, LED and button history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_prev   <= 1'b0;
      r_react_prev   <= 1'b0;
      r_cnt          <= '0;
      r_led_on       <= 1'b0;
      r_result_ms    <= '0;
      r_result_valid <= 1'b0;
      r_best_ms      <= '1;
      r_false_start  <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_start_prev   <= start_btn;
      r_react_prev   <= react_btn;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_FALSE_START: begin
          if (w_start_edge) begin
            r_cnt         <= '0;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (w_react_edge) begin
            r_false_start <= 1'b1;
          end else if (w_wait_done) begin
            r_cnt    <= '0;
            r_led_on <= 1'b1;
          end else if (ms_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_REACT: begin
          if (w_react_edge) begin
            // Pre-increment count is the measured time even if a tick coincides
            r_result_ms    <= r_cnt;
            r_result_valid <= 1'b1;
            r_led_on       <= 1'b0;
            if (r_cnt < r_best_ms) r_best_ms <= r_cnt;
          end else if (w_timeout_hit) begin
            r_cnt          <= CNT_W'(TIMEOUT_MS);
            r_result_ms    <= CNT_W'(TIMEOUT_MS);
            r_result_valid <= 1'b1;
            r_timeout      <= 1'b1;
            r_led_on       <= 1'b0;
          end else if (ms_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign led_on       = r_led_on;
  assign result_ms    = r_result_ms;
  assign result_valid = r_result_valid;
  assign best_ms      = r_best_ms;
  assign false_start  = r_false_start;
  assign timeout      = r_timeout;

endmodule
